// File: rtl/gpu_wb_slave_if.sv
// Wishbone B4 classic slave front-end: decodes the address into NUM_RGN regions and drives one-hot strobes.
// Latency: write ack in cycle 2, read ack in cycle RD_LAT+2 and unmapped err in cycle 1 (cycle 0 = request sampled).
// Backpressure: waits while the selected region is busy, and gives an err after TIMEOUT consecutive busy cycles.
module gpu_wb_slave_if #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int NUM_RGN = 4,
  parameter int RGN_MSB = 15,
  parameter int RGN_LSB = 12,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk_100MHz,
  input  logic                        reset_n,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [DATA_W/8-1:0]         wb_sel_i,
  input  logic [ADDR_W-1:0]           wb_adr_i,
  input  logic [DATA_W-1:0]           wb_dat_i,
  output logic [DATA_W-1:0]           wb_dat_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic [NUM_RGN-1:0]          o_rgn_we,
  output logic [NUM_RGN-1:0]          o_rgn_re,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [DATA_W-1:0]           o_wdata,
  output logic [DATA_W/8-1:0]         o_wsel,
  input  logic [NUM_RGN*DATA_W-1:0]   i_rgn_rdata,
  input  logic [NUM_RGN-1:0]          i_rgn_busy
);

  localparam int SEL_W = DATA_W / 8;
  localparam int RGN_W = RGN_MSB - RGN_LSB + 1;
  localparam int BC_W  = $clog2(TIMEOUT + 1);
  localparam int WC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT_RD,
    S_RESP_ACK,
    S_RESP_ERR
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [RGN_W-1:0]    w_rgn;
  logic [NUM_RGN-1:0]  w_rgn_dec;
  logic [NUM_RGN-1:0]  w_rgn_we;
  logic [NUM_RGN-1:0]  w_rgn_re;
  logic                w_req;
  logic                w_mapped;
  logic                w_busy;
  logic                w_sel_any;
  logic                w_cur_we;
  logic [DATA_W-1:0]   w_rdata_sel;

  logic [NUM_RGN-1:0]  r_rgn_oh;
  logic                r_we;
  logic [BC_W-1:0]     r_busy_cnt;
  logic [WC_W-1:0]     r_wait_cnt;
  logic                r_ack;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [SEL_W-1:0]    r_wsel;

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_rgn     = wb_adr_i[RGN_MSB:RGN_LSB];
  assign w_mapped  = |w_rgn_dec;
  assign w_busy    = |(i_rgn_busy & r_rgn_oh);
  assign w_sel_any = |r_wsel;
  // The direction of the transfer is still on the bus in IDLE, and is latched after that.
  assign w_cur_we  = (r_state == S_IDLE) ? wb_we_i : r_we;

  assign wb_ack_o  = r_ack;
  assign wb_err_o  = r_err;
  assign wb_dat_o  = r_rdata;
  assign o_rgn_we  = w_rgn_we;
  assign o_rgn_re  = w_rgn_re;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_wsel    = r_wsel;

  // Decode the region field to one-hot; indices at or above NUM_RGN decode to all-zero (unmapped).
  always_comb begin
    w_rgn_dec = '0;
    for (int k = 0; k < NUM_RGN; k++) begin
      w_rgn_dec[k] = (w_rgn == RGN_W'(k));
    end
  end

  // Read-data mux for the latched region (an AND-OR select, because the region select is one-hot).
  always_comb begin
    w_rdata_sel = '0;
    for (int k = 0; k < NUM_RGN; k++) begin
      if (r_rgn_oh[k]) begin
        w_rdata_sel = w_rdata_sel | i_rgn_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and region strobes. A master abort takes priority over issuing a strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_rgn_we    = '0;
    w_rgn_re    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = w_mapped ? S_ACCESS : S_RESP_ERR;
        end
      end
      S_ACCESS: begin
        if (!wb_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_busy) begin
          if (r_busy_cnt == BC_W'(TIMEOUT - 1)) begin
            w_state_nxt = S_RESP_ERR;
          end
        end else if (r_we) begin
          // A write with no byte lanes enabled still completes, but the region is not touched.
          if (w_sel_any) begin
            w_rgn_we = r_rgn_oh;
          end
          w_state_nxt = S_RESP_ACK;
        end else begin
          w_rgn_re    = r_rgn_oh;
          w_state_nxt = S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (!wb_cyc_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_wait_cnt == '0) begin
          w_state_nxt = S_RESP_ACK;
        end
      end
      S_RESP_ACK: w_state_nxt = S_IDLE;
      S_RESP_ERR: w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: request latch, busy/wait counters, read-data capture and the registered responses.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      r_rgn_oh   <= '0;
      r_we       <= 1'b0;
      r_busy_cnt <= '0;
      r_wait_cnt <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wsel     <= '0;
    end else begin
      r_ack <= (w_state_nxt == S_RESP_ACK);
      r_err <= (w_state_nxt == S_RESP_ERR);

      if (r_state == S_IDLE && w_req) begin
        r_addr     <= wb_adr_i;
        r_wdata    <= wb_dat_i;
        r_wsel     <= wb_sel_i;
        r_we       <= wb_we_i;
        r_rgn_oh   <= w_rgn_dec;
        r_busy_cnt <= '0;
      end

      if (r_state == S_ACCESS && wb_cyc_i && w_busy) begin
        r_busy_cnt <= r_busy_cnt + BC_W'(1);
      end

      if (|w_rgn_re) begin
        r_wait_cnt <= WC_W'(RD_LAT - 1);
      end

      if (r_state == S_WAIT_RD && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - WC_W'(1);
      end

      if (r_state == S_WAIT_RD && wb_cyc_i && r_wait_cnt == '0) begin
        r_rdata <= w_rdata_sel;
      end

      // Reads that end in an error return zero data; for writes, wb_dat_o keeps its value.
      if (w_state_nxt == S_RESP_ERR && !w_cur_we) begin
        r_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gpu_wb_slave_if.sv
// Bench for gpu_wb_slave_if: a table of transfers plus hand-written abort, reset and back-to-back sequences.
// Expected strobes and responses are queued when a request is driven, then popped by the monitor.
// Region read data is valid only in the exact cycle RD_LAT after the read strobe; it is garbage in every other cycle.
module tb_gpu_wb_slave_if;

  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 32;
  localparam int NUM_RGN = 4;
  localparam int RD_LAT  = 2;

  logic                      clk_100MHz = 1'b0;
  logic                      reset_n    = 1'b0;
  logic                      wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]                wb_sel_i;
  logic [ADDR_W-1:0]         wb_adr_i;
  logic [DATA_W-1:0]         wb_dat_i;
  logic [DATA_W-1:0]         wb_dat_o;
  logic                      wb_ack_o, wb_err_o;
  logic [NUM_RGN-1:0]        o_rgn_we, o_rgn_re;
  logic [ADDR_W-1:0]         o_addr;
  logic [DATA_W-1:0]         o_wdata;
  logic [3:0]                o_wsel;
  logic [NUM_RGN*DATA_W-1:0] i_rgn_rdata;
  logic [NUM_RGN-1:0]        i_rgn_busy;

  gpu_wb_slave_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_RGN(NUM_RGN), .RGN_MSB(15), .RGN_LSB(12),
    .RD_LAT(RD_LAT), .TIMEOUT(15)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset_n(reset_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .o_rgn_we(o_rgn_we), .o_rgn_re(o_rgn_re), .o_addr(o_addr), .o_wdata(o_wdata), .o_wsel(o_wsel),
    .i_rgn_rdata(i_rgn_rdata), .i_rgn_busy(i_rgn_busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int cyc_n = 0;
  always @(posedge clk_100MHz) cyc_n <= cyc_n + 1;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic        we;
    logic [26:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          busy;    // region busy for cycles 1..busy
    logic [31:0] rdata;   // data the addressed region returns
    int          e_stb;   // strobe cycle, -1 = no strobe
    logic [3:0]  e_we;
    logic [3:0]  e_re;
    int          e_resp;  // response cycle
    logic        e_err;
    logic [31:0] e_dat;
  } vec_t;

  typedef struct { int cyc; logic [3:0] we; logic [3:0] re; } stb_exp_t;
  typedef struct { int cyc; logic err; logic chk_dat; logic [31:0] dat; } rsp_exp_t;

  stb_exp_t stb_q[$];
  rsp_exp_t rsp_q[$];

  logic [31:0]        rgn_val [NUM_RGN];
  int                 rd_valid_cyc = -1;
  logic [NUM_RGN-1:0] rd_oh = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Region read-data model: the addressed region is valid only in cycle (read strobe + RD_LAT).
  always_comb begin
    i_rgn_rdata = '0;
    for (int k = 0; k < NUM_RGN; k++) begin
      i_rgn_rdata[k*DATA_W +: DATA_W] = (cyc_n == rd_valid_cyc && rd_oh[k]) ? rgn_val[k]
                                        : (32'hBAD0_0000 | 32'(cyc_n));
    end
  end

  // Monitor: compares strobes and responses against the scoreboard queues.
  stb_exp_t se;
  rsp_exp_t re;
  always @(negedge clk_100MHz) begin
    #2;
    if (reset_n) begin
      if (|{o_rgn_we, o_rgn_re}) begin
        check("strobe onehot", 32'($countones({o_rgn_we, o_rgn_re})), 32'd1);
        if (|o_rgn_re) begin
          rd_valid_cyc = cyc_n + RD_LAT;
          rd_oh        = o_rgn_re;
        end
        if (stb_q.size() == 0) begin
          check("unexpected strobe", 32'({o_rgn_we, o_rgn_re}), 32'd0);
        end else begin
          se = stb_q.pop_front();
          check("strobe cycle", 32'(cyc_n), 32'(se.cyc));
          check("o_rgn_we", 32'(o_rgn_we), 32'(se.we));
          check("o_rgn_re", 32'(o_rgn_re), 32'(se.re));
        end
      end
      if (wb_ack_o || wb_err_o) begin
        check("ack/err exclusive", 32'(wb_ack_o & wb_err_o), 32'd0);
        if (rsp_q.size() == 0) begin
          check("unexpected response", 32'({wb_ack_o, wb_err_o}), 32'd0);
        end else begin
          re = rsp_q.pop_front();
          check("response cycle", 32'(cyc_n), 32'(re.cyc));
          check("wb_err_o", 32'(wb_err_o), 32'(re.err));
          check("wb_ack_o", 32'(wb_ack_o), 32'(!re.err));
          if (re.chk_dat) check("wb_dat_o", wb_dat_o, re.dat);
        end
      end
    end
  end

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_sel_i = '0;   wb_adr_i = '0;   wb_dat_i = '0;
  endtask

  // Drive a request in the current cycle (cycle 0) and queue what it should produce.
  task automatic drive_req(input vec_t v, input bit want_rsp, output int t0);
    stb_exp_t s;
    rsp_exp_t r;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we;
    wb_adr_i = v.adr; wb_dat_i = v.dat; wb_sel_i = v.sel;
    rgn_val[v.adr[13:12]] = v.rdata;
    t0 = cyc_n;
    if (v.e_stb >= 0) begin
      s.cyc = t0 + v.e_stb; s.we = v.e_we; s.re = v.e_re;
      stb_q.push_back(s);
    end
    if (want_rsp) begin
      r.cyc = t0 + v.e_resp; r.err = v.e_err; r.chk_dat = !v.we; r.dat = v.e_dat;
      rsp_q.push_back(r);
    end
  endtask

  // Apply the busy profile, check the latched request in cycle 1, and return the response cycle (-1 = none).
  task automatic wait_resp(input vec_t v, input int t0, output int rc);
    rc = -1;
    for (int i = 0; i < 40 && rc < 0; i++) begin
      @(negedge clk_100MHz);
      i_rgn_busy = (cyc_n >= t0 + 1 && cyc_n <= t0 + v.busy) ? (4'b0001 << v.adr[13:12]) : 4'b0000;
      #3;
      if (cyc_n == t0 + 1) begin
        check("o_addr", 32'(o_addr), 32'(v.adr));
        check("o_wdata", o_wdata, v.dat);
        check("o_wsel", 32'(o_wsel), 32'(v.sel));
      end
      if (wb_ack_o || wb_err_o) rc = cyc_n - t0;
    end
    if (rc < 0) check("response timeout", 32'(rc), 32'(v.e_resp));
    i_rgn_busy = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " wb_ack_o"}, 32'(wb_ack_o), 32'd0);
    check({tag, " wb_err_o"}, 32'(wb_err_o), 32'd0);
    check({tag, " wb_dat_o"}, wb_dat_o, 32'd0);
    check({tag, " strobes"},  32'({o_rgn_we, o_rgn_re}), 32'd0);
    check({tag, " o_addr"},   32'(o_addr), 32'd0);
    check({tag, " o_wdata"},  o_wdata, 32'd0);
    check({tag, " o_wsel"},   32'(o_wsel), 32'd0);
  endtask

  vec_t tbl [12];
  vec_t vb0, vb1, vab, vpa, vrs;
  int   t0, t0a, rc;

  initial begin
    idle_bus();
    i_rgn_busy = '0;
    for (int k = 0; k < NUM_RGN; k++) rgn_val[k] = '0;

    //        we    adr           dat           sel   busy rdata         stb we      re      rsp err   dat
    tbl[0]  = '{1'b1, 27'h0001004, 32'hDEADBEEF, 4'hF, 0,  32'h0,        1,  4'b0010, 4'b0000, 2,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 27'h0003010, 32'h0,        4'hF, 0,  32'h12345678, 1,  4'b0000, 4'b1000, 4,  1'b0, 32'h12345678};
    tbl[2]  = '{1'b0, 27'h0005000, 32'h0,        4'hF, 0,  32'h0,        -1, 4'b0000, 4'b0000, 1,  1'b1, 32'h0};
    tbl[3]  = '{1'b1, 27'h0007FFC, 32'h00000055, 4'hF, 0,  32'h0,        -1, 4'b0000, 4'b0000, 1,  1'b1, 32'h0};
    tbl[4]  = '{1'b1, 27'h0002008, 32'h0000CAFE, 4'hF, 5,  32'h0,        6,  4'b0100, 4'b0000, 7,  1'b0, 32'h0};
    tbl[5]  = '{1'b1, 27'h0002010, 32'h00000077, 4'hF, 15, 32'h0,        -1, 4'b0000, 4'b0000, 16, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 27'h0001FFC, 32'h0,        4'hF, 3,  32'hA5A5A5A5, 4,  4'b0000, 4'b0010, 7,  1'b0, 32'hA5A5A5A5};
    tbl[7]  = '{1'b0, 27'h0000020, 32'h0,        4'hF, 15, 32'h0,        -1, 4'b0000, 4'b0000, 16, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 27'h0000000, 32'h00000099, 4'h0, 0,  32'h0,        -1, 4'b0000, 4'b0000, 2,  1'b0, 32'h0};
    tbl[9]  = '{1'b1, 27'h0003ABC, 32'h00001234, 4'h3, 0,  32'h0,        1,  4'b1000, 4'b0000, 2,  1'b0, 32'h0};
    tbl[10] = '{1'b0, 27'h0000040, 32'h0,        4'hF, 0,  32'h0BADF00D, 1,  4'b0000, 4'b0001, 4,  1'b0, 32'h0BADF00D};
    tbl[11] = '{1'b1, 27'h4001004, 32'h87654321, 4'hF, 14, 32'h0,        15, 4'b0010, 4'b0000, 16, 1'b0, 32'h0};

    vb0 = '{1'b1, 27'h0000010, 32'h11112222, 4'hF, 0, 32'h0,        1, 4'b0001, 4'b0000, 2, 1'b0, 32'h0};
    vb1 = '{1'b0, 27'h0001020, 32'h0,        4'hF, 0, 32'hCAFEF00D, 1, 4'b0000, 4'b0010, 4, 1'b0, 32'hCAFEF00D};
    vab = '{1'b0, 27'h0001100, 32'h0,        4'hF, 0, 32'h77778888, 1, 4'b0000, 4'b0010, 4, 1'b0, 32'h0};
    vpa = '{1'b1, 27'h0003000, 32'h00005A5A, 4'hF, 0, 32'h0,        1, 4'b1000, 4'b0000, 2, 1'b0, 32'h0};
    vrs = '{1'b1, 27'h0002200, 32'h9999AAAA, 4'hF, 0, 32'h0,        -1, 4'b0000, 4'b0000, 0, 1'b0, 32'h0};

    // Reset state.
    repeat (3) @(negedge clk_100MHz);
    #3;
    check_all_zero("reset");
    @(negedge clk_100MHz);
    reset_n = 1'b1;

    // Table of single transfers.
    foreach (tbl[i]) begin
      @(negedge clk_100MHz);
      drive_req(tbl[i], 1'b1, t0);
      wait_resp(tbl[i], t0, rc);
      idle_bus();
    end

    // Back-to-back: a write, then a read whose strobe is reasserted in the cycle after the ack.
    @(negedge clk_100MHz);
    drive_req(vb0, 1'b1, t0a);
    wait_resp(vb0, t0a, rc);
    check("b2b write ack cycle", 32'(rc), 32'd2);
    idle_bus();
    @(negedge clk_100MHz);
    drive_req(vb1, 1'b1, t0);
    wait_resp(vb1, t0, rc);
    check("b2b read ack cycle", 32'(t0 + rc - t0a), 32'd7);
    idle_bus();

    // Master abort during WAIT_RD: no ack, and the earlier read data is kept.
    @(negedge clk_100MHz);
    drive_req(vab, 1'b0, t0);
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    idle_bus();
    repeat (6) @(negedge clk_100MHz);
    #3;
    check("abort keeps wb_dat_o", wb_dat_o, 32'hCAFEF00D);
    check("abort strobe drained", 32'(stb_q.size()), 32'd0);
    @(negedge clk_100MHz);
    drive_req(vpa, 1'b1, t0);
    wait_resp(vpa, t0, rc);
    idle_bus();

    // Reset in the middle of ACCESS while the region is busy.
    @(negedge clk_100MHz);
    drive_req(vrs, 1'b0, t0);
    @(negedge clk_100MHz); i_rgn_busy = 4'b0100;
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    reset_n = 1'b0;
    @(negedge clk_100MHz);
    #3;
    check_all_zero("mid-access reset");
    idle_bus();
    i_rgn_busy = '0;
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    drive_req(tbl[0], 1'b1, t0);
    wait_resp(tbl[0], t0, rc);
    idle_bus();
    repeat (3) @(negedge clk_100MHz);

    check("strobe queue empty", 32'(stb_q.size()), 32'd0);
    check("response queue empty", 32'(rsp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/gpu_wb_slave_if.md
Name: gpu_wb_slave_if

Overview:
Parametrised Wishbone B4 classic slave front-end for the GPU register/memory space. It replaces the free-running half-rate write-enable scheme with a real STB/ACK/ERR handshake and decodes an address field into NUM_RGN regions (control registers, sprite table, tile map, texture memory, ...). It issues single-cycle write/read strobes to the selected region, waits a fixed read latency, and returns read data. It also honours per-region busy back-pressure, with a timeout, and flags unmapped accesses with an error.

Parameters:
ADDR_W, 27, Wishbone address width
DATA_W, 32, data width; must be a multiple of 8
NUM_RGN, 4, number of decoded regions (1..16)
RGN_MSB, 15, MSB of region-select field in wb_adr_i
RGN_LSB, 12, LSB of region-select field
RD_LAT, 2, cycles from read-strobe cycle to region read data valid (>=1)
TIMEOUT, 15, max consecutive busy cycles before error (>=1)

Ports:
clk_100MHz  in  1  clock; reset reset_n, synchronous, active-low; clock clk_100MHz
reset_n  in  1  synchronous active-low reset
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  1=write
wb_sel_i  in  DATA_W/8  byte selects
wb_adr_i  in  ADDR_W  address
wb_dat_i  in  DATA_W  write data
wb_dat_o  out  DATA_W  read data (registered)
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
o_rgn_we  out  NUM_RGN  one-hot write strobe
o_rgn_re  out  NUM_RGN  one-hot read strobe
o_addr  out  ADDR_W  latched address
o_wdata  out  DATA_W  latched write data
o_wsel  out  DATA_W/8  latched byte selects
i_rgn_rdata  in  NUM_RGN*DATA_W  region read data; region k at [k*DATA_W +: DATA_W]
i_rgn_busy  in  NUM_RGN  region cannot accept a strobe this cycle

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0. Applies at any state; an in-flight transfer is dropped with no ack/err.
- Region index rgn = wb_adr_i[RGN_MSB:RGN_LSB]; rgn >= NUM_RGN is unmapped.
- Timing: cycle 0 = first cycle with cyc&stb in IDLE.
- IDLE: on cyc&stb, latch adr/dat/sel/we into o_addr/o_wdata/o_wsel and rgn.
  - Unmapped -> RESP_ERR.
  - Otherwise -> ACCESS; busy counter cleared.
- ACCESS:
  - If i_rgn_busy[rgn]=1: stay and increment the busy counter. When the counter reaches TIMEOUT -> RESP_ERR with no strobe issued.
  - If i_rgn_busy[rgn]=0, write: o_rgn_we[rgn]=1 for exactly this cycle -> RESP_ACK.
  - If i_rgn_busy[rgn]=0, read: o_rgn_re[rgn]=1 for exactly this cycle; load wait counter with RD_LAT-1 -> WAIT_RD.
  - Strobes are combinational from state/rgn/busy; at most one strobe bit is high in any cycle.
- WAIT_RD: decrement each cycle. At counter 0, capture the i_rgn_rdata slice for rgn into wb_dat_o -> RESP_ACK.
  - Data must be valid RD_LAT cycles after the read-strobe cycle.
- RESP_ACK / RESP_ERR:
  - wb_ack_o (resp. wb_err_o) is registered and high exactly one cycle -> IDLE.
  - ack and err are never high together.
  - Error reads load wb_dat_o=0. Otherwise wb_dat_o holds its last captured value.
- Latency, no busy: write ack in cycle 2; read ack in cycle RD_LAT+2; unmapped err in cycle 1.
- Back-to-back: a new cyc&stb sampled in IDLE the cycle after RESP starts a new transfer. One outstanding transfer max; wb_stb_i is ignored outside IDLE.
- Master abort: wb_cyc_i=0 in ACCESS or WAIT_RD returns the FSM to IDLE next edge with no ack/err. A strobe already issued is not retracted; a pending read capture is discarded.
- Write with wb_sel_i all zero: no o_rgn_we strobe, still ack in cycle 2.
- o_addr/o_wdata/o_wsel are stable from cycle 1 until the next IDLE latch.

Test Plan:
- Write, RD_LAT=2: adr=0x1004, dat=0xDEADBEEF, sel=0xF, busy=0 -> o_rgn_we=4'b0010 in cycle 1 only with o_addr=0x1004, o_wdata=0xDEADBEEF; wb_ack_o=1 in cycle 2 only.
- Read, region 3: adr=0x3010, rdata[3]=0x12345678 valid 2 cycles after re -> o_rgn_re=4'b1000 in cycle 1; ack in cycle 4 with wb_dat_o=0x12345678.
- Unmapped: NUM_RGN=4, adr=0x5000 -> no strobes; wb_err_o=1 in cycle 1; wb_dat_o=0 for a read.
- Busy then release: i_rgn_busy[2]=1 for 5 cycles, then 0 -> we strobe in cycle 6, ack in cycle 7. Busy held for 15 cycles -> err in cycle 16, no strobe.
- Abort and reset: wb_cyc_i drops during WAIT_RD -> no ack, FSM back in IDLE, next write completes normally. reset_n=0 mid-ACCESS -> all outputs 0 next edge, no ack ever issued.
- Back-to-back: write to region 0 then read from region 1 with stb reasserted the cycle after ack -> ack cycles 2 and 7 (RD_LAT=2); strobes never overlap.
